// File: rtl/load_store_unit.sv
// Load/store unit: bridges one core memory request at a time onto a word-wide bus.
// Optional misalignment trapping is enabled by defining LSU_MISALIGN_CHECK_EN.
module load_store_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         we,
  input  logic [2:0]   funct3,
  input  logic [N-1:0] addr,
  input  logic [N-1:0] wdata,
  output logic         rsp_valid,
  output logic [N-1:0] rdata,
  output logic         busy,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  output logic [3:0]   mem_be,
  input  logic         mem_ack,
  input  logic [N-1:0] mem_rdata,
`ifdef LSU_MISALIGN_CHECK_EN
  output logic         misaligned,
`endif
  output logic [1:0]   dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // the bus access transfers on the edge where mem_req && mem_ack.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic         we_q, we_d;
  logic [2:0]   funct3_q, funct3_d;
  logic [1:0]   lane_q, lane_d;
  logic [3:0]   be_q, be_d;
  logic [N-1:0] addr_q, addr_d;
  logic [N-1:0] wdata_q, wdata_d;
  logic [N-1:0] rdata_q, rdata_d;
`ifdef LSU_MISALIGN_CHECK_EN
  logic         mis_q, mis_d;
`endif

  logic         is_byte, is_half, is_word;
  logic         illegal, misalign;
  logic [1:0]   lane_req;
  logic [3:0]   be_req;
  logic [N-1:0] wdata_rep;
  logic [N-1:0] shifted;
  logic [N-1:0] load_ext;

  // Request decode (combinational on the incoming request)
  always_comb begin
    is_byte  = (funct3[1:0] == 2'b00);
    is_half  = (funct3[1:0] == 2'b01);
    is_word  = (funct3[1:0] == 2'b10);
    illegal  = (funct3 == 3'b011) || (funct3[2] && funct3[1]) || (we && funct3[2]);
`ifdef LSU_MISALIGN_CHECK_EN
    misalign = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    // Without the check, low address bits below the access size are dropped.
    if (is_byte)      lane_req = addr[1:0];
    else if (is_half) lane_req = {addr[1], 1'b0};
    else              lane_req = 2'b00;

    if (is_byte)      be_req = 4'b0001 << lane_req;
    else if (is_half) be_req = 4'b0011 << lane_req;
    else              be_req = 4'b1111;

    if (is_byte)      wdata_rep = {4{wdata[7:0]}};
    else if (is_half) wdata_rep = {2{wdata[15:0]}};
    else              wdata_rep = wdata;
  end

  // Load alignment and extension from the captured lane
  always_comb begin
    shifted = mem_rdata >> {lane_q, 3'b000};
    case (funct3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_ext = {24'd0, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_ext = {16'd0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    lane_d   = lane_q;
    be_d     = be_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
`ifdef LSU_MISALIGN_CHECK_EN
    mis_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d     = we;
          funct3_d = funct3;
          lane_d   = lane_req;
          be_d     = be_req;
          addr_d   = {addr[N-1:2], 2'b00};
          wdata_d  = wdata_rep;
          if (illegal || misalign) begin
            state_d = S_RESP;
            rdata_d = '0;
`ifdef LSU_MISALIGN_CHECK_EN
            mis_d   = misalign && !illegal;
`endif
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          state_d = S_RESP;
          rdata_d = we_q ? '0 : load_ext;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      lane_q   <= 2'd0;
      be_q     <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
      mis_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      lane_q   <= lane_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
`ifdef LSU_MISALIGN_CHECK_EN
      mis_q    <= mis_d;
`endif
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rdata     = rdata_q;
  assign mem_req   = (state_q == S_REQ);
  assign mem_we    = mem_req && we_q;
  assign mem_be    = mem_req ? be_q : 4'd0;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign dbg_state = state_q;
`ifdef LSU_MISALIGN_CHECK_EN
  assign misaligned = mis_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed scoreboard bench for load_store_unit; honours LSU_MISALIGN_CHECK_EN.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;
`ifdef LSU_MISALIGN_CHECK_EN
  logic        misaligned;
`endif

  load_store_unit #(.N(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .we        (we),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .rsp_valid (rsp_valid),
    .rdata     (rdata),
    .busy      (busy),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
`ifdef LSU_MISALIGN_CHECK_EN
    .misaligned(misaligned),
`endif
    .dbg_state (dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];
  logic        exp_mis_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every response pops one expectation
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected none (t=%0t)", $time);
      end else begin
        chk("rsp_rdata", rdata, exp_q.pop_front());
        chk("rsp_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
`ifdef LSU_MISALIGN_CHECK_EN
        chk("rsp_misaligned", 32'(misaligned), 32'(exp_mis_q.pop_front()));
`else
        void'(exp_mis_q.pop_front());
`endif
      end
    end
  end

  // Driver: one full access, entered and left at posedge+1 with the DUT idle
  task automatic do_access(input logic we_v, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] bus_rd, input int waits,
                           input logic bus, input logic [3:0] ebe, input logic [31:0] eaddr,
                           input logic [31:0] ewd, input logic [31:0] erd, input logic emis);
    int k;
    req_valid = 1'b1;
    we        = we_v;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    k = cyc;
    req_valid = 1'b0;
    exp_q.push_back(erd);
    exp_cyc_q.push_back(bus ? (k + 1 + waits) : k);
    exp_mis_q.push_back(emis);
    if (bus) begin
      for (int i = 0; i <= waits; i++) begin
        @(negedge clk);
        chk("mem_req", 32'(mem_req), 32'd1);
        chk("mem_we", 32'(mem_we), 32'(we_v));
        chk("mem_addr", mem_addr, eaddr);
        chk("mem_be", 32'(mem_be), 32'(ebe));
        if (we_v) chk("mem_wdata", mem_wdata, ewd);
        if (i == waits) begin
          mem_ack   = 1'b1;
          mem_rdata = bus_rd;
        end
        @(posedge clk);
        #1;
      end
      mem_ack   = 1'b0;
      mem_rdata = 32'hA5A5_A5A5;
    end else begin
      @(negedge clk);
      chk("no_mem_req", 32'(mem_req), 32'd0);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rdata_hold", rdata, erd);
    chk("busy_idle", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    we        = 1'b0;
    funct3    = 3'd0;
    addr      = 32'd0;
    wdata     = 32'd0;
    mem_ack   = 1'b0;
    mem_rdata = 32'hA5A5_A5A5;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_state", 32'(dbg_state), 32'd0);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("rst_misaligned", 32'(misaligned), 32'd0);
`endif
    @(posedge clk);
    #1;

    //        we  f3      addr          wdata         bus_rd        w  bus  be       eaddr         ewdata        erdata        mis
    do_access(1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        0, 1, 4'b1111, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        0);
    do_access(0, 3'b000, 32'h0000_0203, 32'h0,        32'h80FF_1234, 0, 1, 4'b1000, 32'h0000_0200, 32'h0,        32'hFFFF_FF80, 0);
    do_access(0, 3'b100, 32'h0000_0203, 32'h0,        32'h80FF_1234, 0, 1, 4'b1000, 32'h0000_0200, 32'h0,        32'h0000_0080, 0);
    do_access(1, 3'b001, 32'h0000_0302, 32'h0000_ABCD, 32'h0,        3, 1, 4'b1100, 32'h0000_0300, 32'hABCD_ABCD, 32'h0,        0);
`ifdef LSU_MISALIGN_CHECK_EN
    do_access(0, 3'b001, 32'h0000_0101, 32'h0,        32'h1234_F00D, 0, 0, 4'b0000, 32'h0,        32'h0,        32'h0,        1);
    do_access(0, 3'b010, 32'h0000_0102, 32'h0,        32'hCAFE_F00D, 0, 0, 4'b0000, 32'h0,        32'h0,        32'h0,        1);
`else
    do_access(0, 3'b001, 32'h0000_0101, 32'h0,        32'h1234_F00D, 0, 1, 4'b0011, 32'h0000_0100, 32'h0,        32'hFFFF_F00D, 0);
    do_access(0, 3'b010, 32'h0000_0102, 32'h0,        32'hCAFE_F00D, 0, 1, 4'b1111, 32'h0000_0100, 32'h0,        32'hCAFE_F00D, 0);
`endif
    do_access(0, 3'b111, 32'h0000_0100, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        32'h0,        0);
    do_access(0, 3'b101, 32'h0000_0102, 32'h0,        32'h8001_7FFF, 1, 1, 4'b1100, 32'h0000_0100, 32'h0,        32'h0000_8001, 0);
    do_access(0, 3'b010, 32'h0000_0104, 32'h0,        32'h1357_9BDF, 0, 1, 4'b1111, 32'h0000_0104, 32'h0,        32'h1357_9BDF, 0);
    do_access(1, 3'b000, 32'h0000_0107, 32'h1234_56AB, 32'h0,        2, 1, 4'b1000, 32'h0000_0104, 32'hABAB_ABAB, 32'h0,        0);
    do_access(1, 3'b100, 32'h0000_0010, 32'h1111_2222, 32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        32'h0,        0);
    do_access(0, 3'b001, 32'h0000_0202, 32'h0,        32'h8001_7FFF, 0, 1, 4'b1100, 32'h0000_0200, 32'h0,        32'hFFFF_8001, 0);
    do_access(0, 3'b000, 32'h0000_0001, 32'h0,        32'h0000_7F00, 0, 1, 4'b0010, 32'h0000_0000, 32'h0,        32'h0000_007F, 0);
    do_access(0, 3'b011, 32'h0000_0200, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        32'h0,        0);
    do_access(0, 3'b010, 32'h0000_0104, 32'h0,        32'h0BAD_CAFE, 2, 1, 4'b1111, 32'h0000_0104, 32'h0,        32'h0BAD_CAFE, 0);

    // A stray bus acknowledge while idle must not start anything
    mem_ack = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_busy", 32'(busy), 32'd0);
    chk("idle_ack_mem_req", 32'(mem_req), 32'd0);
    @(posedge clk);
    #1;

    // Reset in the middle of a waiting load abandons the access
    req_valid = 1'b1;
    we        = 1'b0;
    funct3    = 3'b010;
    addr      = 32'h0000_0400;
    @(negedge clk);
    chk("rstmid_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_req1", 32'(mem_req), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_req2", 32'(mem_req), 32'd1);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h7777_7777;
    @(negedge clk);
    chk("rstmid_mem_req", 32'(mem_req), 32'd0);
    chk("rstmid_req_ready", 32'(req_ready), 32'd1);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_rdata", rdata, 32'd0);
    @(posedge clk);
    #1;
    mem_ack   = 1'b0;
    mem_rdata = 32'hA5A5_A5A5;
    repeat (3) begin
      @(negedge clk);
      chk("rstmid_after_busy", 32'(busy), 32'd0);
    end
    @(posedge clk);
    #1;

    chk("pending_rsp", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: N, default 32, datapath width; only N = 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  core requests a memory access.
REQ-005 req_ready  output  1  unit can accept a request; high only in IDLE.
REQ-006 we  input  1  1 = store, 0 = load.
REQ-007 funct3  input  3  access type: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-008 addr  input  N  byte address, taken from the ALU result.
REQ-009 wdata  input  N  store data (rs2).
REQ-010 rsp_valid  output  1  one-cycle pulse; access complete.
REQ-011 rdata  output  N  aligned, extended load data, valid with rsp_valid.
REQ-012 busy  output  1  stall to core; high in REQ and RESP.
REQ-013 mem_req  output  1  bus request.
REQ-014 mem_we  output  1  bus write enable.
REQ-015 mem_addr  output  N  word address; bits [1:0] always 0.
REQ-016 mem_wdata  output  N  lane-replicated store data.
REQ-017 mem_be  output  4  byte enables.
REQ-018 mem_ack  input  1  bus completion; sampled only in REQ.
REQ-019 mem_rdata  input  N  bus read data, valid with mem_ack.

Function
REQ-020 FSM states: IDLE, REQ, RESP.
REQ-021 IDLE->REQ on req_valid; we, funct3, addr, wdata, be and lane are registered on that edge.
REQ-022 REQ: mem_req=1; mem_we, mem_addr, mem_be and mem_wdata held stable until mem_ack; REQ->RESP on mem_ack.
REQ-023 RESP: rsp_valid=1 for exactly one cycle; RESP->IDLE unconditionally.
REQ-024 Zero-wait latency: request accepted at edge k; mem_req high in cycle k+1; with mem_ack in k+1, rsp_valid high in cycle k+2; each bus wait cycle adds one cycle.
REQ-025 Byte enables: byte = 0001<<addr[1:0]; half = 0011<<(2*addr[1]); word = 1111.
REQ-026 Store data is replicated: byte on all four lanes, half on both halves, word as-is.
REQ-027 Load data: the selected lane is captured on mem_ack; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
REQ-028 Stores complete with rsp_valid and rdata=0.
REQ-029 Illegal funct3 (011, 110, 111, or 100/101 with we=1): IDLE->RESP, no mem_req, rdata=0.
REQ-030 mem_ack in IDLE or RESP is ignored; req_valid outside IDLE is ignored.
REQ-031 rdata holds its value until the next RESP.

Reset
REQ-032 rst forces IDLE from any state on the next edge, including mid-REQ; an outstanding bus access is abandoned.
REQ-033 Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, rsp_valid=0, rdata=0, busy=0, req_ready=1 (after the edge), misaligned=0.

Configuration
REQ-034 Macro LSU_MISALIGN_CHECK_EN defined: output misaligned (1 bit) exists; a half access with addr[0]=1 or a word access with addr[1:0]!=0 goes IDLE->RESP with no mem_req; misaligned=1 with rsp_valid and rdata=0.
REQ-035 Macro undefined: no misaligned port; addr[0] is ignored for half accesses and addr[1:0] for word accesses (forced alignment), so every legal request reaches the bus.

Verification
REQ-036 SW addr=0x100 wdata=0xDEADBEEF, mem_ack in first REQ cycle -> mem_addr=0x100, mem_be=1111, mem_wdata=0xDEADBEEF; rsp_valid 2 cycles after accept; rdata=0.
REQ-037 LB addr=0x203, mem_rdata=0x80FF1234 -> mem_be=1000, rdata=0xFFFFFF80; same access with LBU -> rdata=0x00000080.
REQ-038 SH addr=0x302 wdata=0x0000ABCD, mem_ack delayed 3 cycles -> mem_be=1100, mem_wdata=0xABCDABCD held stable for 4 REQ cycles; rsp_valid 5 cycles after accept.
REQ-039 LW with 2 wait cycles; rst asserted in the second REQ cycle, then mem_ack -> IDLE, mem_req=0, rsp_valid never asserted, req_ready=1.
REQ-040 LH addr=0x101 -> with macro: no mem_req, misaligned=1 and rsp_valid in the cycle after accept, rdata=0; without macro: mem_be=0011, mem_addr=0x100.
REQ-041 funct3=111 -> no mem_req, rsp_valid in the cycle after accept, rdata=0.
